// File: rtl/nmi_core_bridge_if.sv
// NMI master bus bundle: request fields flow master->slave, completion and
// read data flow slave->master.
interface nmi_core_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    nmi_valid_o;
  logic [ADDR_WIDTH-1:0]   nmi_addr_o;
  logic [DATA_WIDTH-1:0]   nmi_wdata_o;
  logic [DATA_WIDTH/8-1:0] nmi_wstrb_o;
  logic                    nmi_ready_i;
  logic [DATA_WIDTH-1:0]   nmi_rdata_i;

  modport master (
    output nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o,
    input  nmi_ready_i, nmi_rdata_i
  );

  modport slave (
    input  nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o,
    output nmi_ready_i, nmi_rdata_i
  );
endinterface

// File: rtl/nmi_core_bridge.sv
// Strobe/busy core memory port to NMI valid/ready master bridge with a
// posted-write FIFO, read-after-write ordering and a bus timeout.
module nmi_core_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    WBUF_DEPTH     = 4,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 'hDEAD_BEEF
)(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [ADDR_WIDTH-1:0]           core_addr_i,
  input  logic [DATA_WIDTH-1:0]           core_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]         core_wmask_i,
  input  logic                            core_rstrb_i,
  output logic [DATA_WIDTH-1:0]           core_rdata_o,
  output logic                            core_rbusy_o,
  output logic                            core_wbusy_o,
  nmi_core_bridge_if.master               nmi,
  output logic                            timeout_o,
  input  logic                            timeout_clr_i,
  output logic [$clog2(WBUF_DEPTH):0]     wbuf_level_o
);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int PW    = $clog2(WBUF_DEPTH);
  localparam int LW    = PW + 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SW-1:0]         mask;
  } wentry_t;

  state_t                state_q, state_d;
  wentry_t               mem [WBUF_DEPTH];
  wentry_t               hold_q, push_data, head;
  logic                  hold_vld;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [LW-1:0]         count;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  tmo_q;
  logic [TW-1:0]         tcnt;

  logic wr_req, rd_req, busy, stall, tmo_hit, done, finish;
  logic pop, full, can_push, push_hold, push_new, to_hold, push;

  // A write wins over a simultaneous read strobe; a pending read masks new strobes.
  assign wr_req    = |core_wmask_i;
  assign rd_req    = core_rstrb_i && !wr_req && !rd_pend;
  assign busy      = (state_q != IDLE);
  assign stall     = busy && !nmi.nmi_ready_i;
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && stall && (tcnt == TW'(TLAST));
  assign done      = busy && nmi.nmi_ready_i;
  assign finish    = done || tmo_hit;
  assign pop       = (state_q == WRITE) && finish;
  assign full      = (count == LW'(WBUF_DEPTH));
  // A pop in the same cycle frees a slot even when the FIFO looks full.
  assign can_push  = !full || pop;
  assign push_hold = hold_vld && can_push;
  assign push_new  = wr_req && !hold_vld && can_push;
  assign to_hold   = wr_req && !hold_vld && !can_push;
  assign push      = push_hold || push_new;
  assign push_data = hold_vld ? hold_q : '{addr: core_addr_i, data: core_wdata_i, mask: core_wmask_i};
  assign head      = mem[rd_ptr];

  // Next-state: reads only go out once the write path is completely drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_pend && count == '0 && !hold_vld) state_d = READ;
        else if (count != '0)                    state_d = WRITE;
      end
      WRITE, READ: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FIFO storage; pointers are reset separately so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and the overflow hold register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (to_hold) begin
        hold_vld <= 1'b1;
        hold_q   <= push_data;
      end else if (push_hold) begin
        hold_vld <= 1'b0;
      end
    end
  end

  // Read request latch and returned data (bus data or error pattern).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (rd_req) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= core_addr_i;
      end else if (state_q == READ && finish) begin
        rd_pend <= 1'b0;
      end
      if (state_q == READ && done)         rdata_q <= nmi.nmi_rdata_i;
      else if (state_q == READ && tmo_hit) rdata_q <= ERR_DATA;
    end
  end

  // Wait counter restarts every transfer; sticky flag where a new timeout beats clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (!busy)      tcnt <= '0;
      else if (stall) tcnt <= tcnt + 1'b1;
      if (tmo_hit)            tmo_q <= 1'b1;
      else if (timeout_clr_i) tmo_q <= 1'b0;
    end
  end

  assign nmi.nmi_valid_o = busy;
  assign nmi.nmi_addr_o  = (state_q == READ)  ? rd_addr_q :
                           (state_q == WRITE) ? head.addr : '0;
  assign nmi.nmi_wdata_o = (state_q == WRITE) ? head.data : '0;
  assign nmi.nmi_wstrb_o = (state_q == WRITE) ? head.mask : '0;

  assign core_rdata_o = rdata_q;
  assign core_rbusy_o = rd_pend;
  assign core_wbusy_o = hold_vld;
  assign timeout_o    = tmo_q;
  assign wbuf_level_o = count;
endmodule

// File: tb/tb_nmi_core_bridge.sv
// Directed bench for nmi_core_bridge with a small NMI slave model and bus log.
module tb_nmi_core_bridge;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
  logic [3:0]  core_wmask_i;
  logic        core_rstrb_i, core_rbusy_o, core_wbusy_o;
  logic        timeout_o, timeout_clr_i;
  logic [2:0]  wbuf_level_o;

  always #5 clk_i = ~clk_i;

  nmi_core_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  nmi_core_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WBUF_DEPTH(4),
                    .TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_wmask_i(core_wmask_i), .core_rstrb_i(core_rstrb_i),
    .core_rdata_o(core_rdata_o), .core_rbusy_o(core_rbusy_o),
    .core_wbusy_o(core_wbusy_o), .nmi(bus),
    .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i),
    .wbuf_level_o(wbuf_level_o)
  );

  // Slave model: mode 0 never ready, 1 always ready, 2 ready after dly wait cycles.
  int          mode = 0, dly = 0, wcnt = 0, nlog = 0;
  bit [255:0]  mv;
  logic [31:0] smem [256];
  logic [31:0] log_a [64], log_d [64];
  logic [3:0]  log_s [64];
  logic [31:0] nv;
  wire  [7:0]  sidx = bus.nmi_addr_o[9:2];

  assign bus.nmi_ready_i = (mode == 1) || (mode == 2 && bus.nmi_valid_o && wcnt >= dly);
  assign bus.nmi_rdata_i = mv[sidx] ? smem[sidx] : 32'h1234_5678;

  always @(posedge clk_i) begin
    if (rst_i || !bus.nmi_valid_o || bus.nmi_ready_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (!rst_i && bus.nmi_valid_o && bus.nmi_ready_i && nlog < 64) begin
      log_a[nlog] <= bus.nmi_addr_o;
      log_d[nlog] <= bus.nmi_wdata_o;
      log_s[nlog] <= bus.nmi_wstrb_o;
      nlog <= nlog + 1;
      if (bus.nmi_wstrb_o != 4'h0) begin
        nv = mv[sidx] ? smem[sidx] : 32'h1234_5678;
        for (int b = 0; b < 4; b++)
          if (bus.nmi_wstrb_o[b]) nv[b*8 +: 8] = bus.nmi_wdata_o[b*8 +: 8];
        smem[sidx] <= nv;
        mv[sidx]   <= 1'b1;
      end
    end
  end

  int vecs = 0, miscmp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    core_addr_i = a; core_wdata_i = d; core_wmask_i = m;
    @(negedge clk_i);
    core_wmask_i = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    core_addr_i = a; core_rstrb_i = 1'b1;
    @(negedge clk_i);
    core_rstrb_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((bus.nmi_valid_o || wbuf_level_o != 0 || core_rbusy_o || core_wbusy_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_drained"}, n < 200, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n, vcnt;
    rst_i = 1'b1; core_addr_i = '0; core_wdata_i = '0; core_wmask_i = '0;
    core_rstrb_i = 1'b0; timeout_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", bus.nmi_valid_o, 1'b0);
    chk("rst_level", wbuf_level_o, 3'd0);
    chk("rst_busy",  {core_rbusy_o, core_wbusy_o, timeout_o}, 3'b000);
    chk("rst_rdata", core_rdata_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single read, ready tied high: valid at C2, data with rbusy low at C3.
    mode = 1; base = nlog;
    rd(32'h40);
    chk("rd1_c1_rbusy", core_rbusy_o, 1'b1);
    chk("rd1_c1_valid", bus.nmi_valid_o, 1'b0);
    @(negedge clk_i);
    chk("rd1_c2_valid", bus.nmi_valid_o, 1'b1);
    chk("rd1_c2_wstrb", bus.nmi_wstrb_o, 4'h0);
    chk("rd1_c2_addr",  bus.nmi_addr_o, 32'h40);
    @(negedge clk_i);
    chk("rd1_c3_rbusy", core_rbusy_o, 1'b0);
    chk("rd1_c3_rdata", core_rdata_o, 32'h1234_5678);
    chk("rd1_c3_valid", bus.nmi_valid_o, 1'b0);
    chk("rd1_nlog", nlog - base, 1);

    // Six writes with ready held low: four buffered, fifth held with wbusy.
    mode = 0; base = nlog;
    for (int i = 0; i < 4; i++) wr(32'h100 + 4*i, 32'hA000_0000 + i, 4'hF);
    chk("wr6_level4", wbuf_level_o, 3'd4);
    chk("wr6_wbusy0", core_wbusy_o, 1'b0);
    chk("wr6_valid",  bus.nmi_valid_o, 1'b1);
    wr(32'h110, 32'hA000_0004, 4'hF);
    chk("wr6_wbusy1", core_wbusy_o, 1'b1);
    chk("wr6_level_hold", wbuf_level_o, 3'd4);
    mode = 1;
    n = 0;
    while (core_wbusy_o && n < 50) begin @(negedge clk_i); n++; end
    chk("wr6_wbusy_release", n < 50, 1'b1);
    wr(32'h114, 32'hA000_0005, 4'hF);
    drain("wr6");
    chk("wr6_count", nlog - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wr6_addr%0d", i), log_a[base+i], 32'h100 + 4*i);
      chk($sformatf("wr6_data%0d", i), log_d[base+i], 32'hA000_0000 + i);
      chk($sformatf("wr6_strb%0d", i), log_s[base+i], 4'hF);
    end

    // Full FIFO popping and pushing in the same cycle: no busy.
    mode = 0; base = nlog;
    for (int i = 0; i < 4; i++) wr(32'h500 + 4*i, 32'hB000_0000 + i, 4'hF);
    chk("pp_level4", wbuf_level_o, 3'd4);
    mode = 1;
    wr(32'h510, 32'hB000_0004, 4'hF);
    chk("pp_wbusy", core_wbusy_o, 1'b0);
    chk("pp_level", wbuf_level_o, 3'd4);
    drain("pp");
    chk("pp_count", nlog - base, 5);
    chk("pp_last",  log_a[base+4], 32'h510);

    // Read after write to the same address, slave ready after 5 wait cycles.
    mode = 2; dly = 5; base = nlog;
    wr(32'h200, 32'hCAFE_F00D, 4'hF);
    rd(32'h200);
    chk("raw_rbusy", core_rbusy_o, 1'b1);
    n = 0;
    while (core_rbusy_o && n < 100) begin @(negedge clk_i); n++; end
    chk("raw_done",   n < 100, 1'b1);
    chk("raw_rdata",  core_rdata_o, 32'hCAFE_F00D);
    chk("raw_count",  nlog - base, 2);
    chk("raw_first",  {log_a[base], log_s[base]}, {32'h200, 4'hF});
    chk("raw_second", {log_a[base+1], log_s[base+1]}, {32'h200, 4'h0});

    // Read with ready never asserted: 16 valid cycles, then error data.
    mode = 0; base = nlog; vcnt = 0; n = 0;
    rd(32'h300);
    while (core_rbusy_o && n < 40) begin
      if (bus.nmi_valid_o) vcnt++;
      @(negedge clk_i);
      n++;
    end
    chk("tmo_vcycles", vcnt, 16);
    chk("tmo_rdata",   core_rdata_o, 32'hDEAD_BEEF);
    chk("tmo_flag",    timeout_o, 1'b1);
    chk("tmo_valid",   bus.nmi_valid_o, 1'b0);
    chk("tmo_nolog",   nlog - base, 0);
    @(negedge clk_i);
    chk("tmo_sticky", timeout_o, 1'b1);
    timeout_clr_i = 1'b1;
    @(negedge clk_i);
    timeout_clr_i = 1'b0;
    chk("tmo_clr", timeout_o, 1'b0);

    // Reset in the middle of a read.
    mode = 0;
    rd(32'h340);
    repeat (2) @(negedge clk_i);
    chk("rstrd_pre_valid", bus.nmi_valid_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rstrd_valid", bus.nmi_valid_o, 1'b0);
    chk("rstrd_flags", {core_rbusy_o, core_wbusy_o, timeout_o}, 3'b000);
    chk("rstrd_rdata", core_rdata_o, 32'h0);
    mode = 1; base = nlog;
    repeat (5) @(negedge clk_i);
    chk("rstrd_quiet", {nlog - base, 31'(0), bus.nmi_valid_o, core_rbusy_o}, 64'h0);

    // Reset with the FIFO full and a write held.
    mode = 0;
    for (int i = 0; i < 5; i++) wr(32'h600 + 4*i, 32'hC000_0000 + i, 4'hF);
    chk("rstfull_pre", {core_wbusy_o, wbuf_level_o}, {1'b1, 3'd4});
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rstfull_level", wbuf_level_o, 3'd0);
    chk("rstfull_wbusy", core_wbusy_o, 1'b0);
    chk("rstfull_bus",   {bus.nmi_valid_o, bus.nmi_addr_o, bus.nmi_wstrb_o}, 37'h0);
    mode = 1; base = nlog;
    repeat (5) @(negedge clk_i);
    chk("rstfull_nolog", nlog - base, 0);
    chk("rstfull_idle",  {bus.nmi_valid_o, wbuf_level_o}, 4'h0);

    // Simultaneous read strobe and write: only the write goes out.
    mode = 1; base = nlog;
    core_addr_i = 32'h400; core_wdata_i = 32'h1122_3344;
    core_wmask_i = 4'h3; core_rstrb_i = 1'b1;
    @(negedge clk_i);
    core_wmask_i = 4'h0; core_rstrb_i = 1'b0;
    chk("sim_rbusy", core_rbusy_o, 1'b0);
    repeat (6) @(negedge clk_i);
    chk("sim_rbusy_end", core_rbusy_o, 1'b0);
    chk("sim_count", nlog - base, 1);
    chk("sim_entry", {log_a[base], log_d[base], log_s[base]}, {32'h400, 32'h1122_3344, 4'h3});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule

// File: doc/nmi_core_bridge.md
Name: nmi_core_bridge

Overview:
Parametrised bridge between a FemtoRV-style strobe/busy core memory port and the SoC NMI master bus (valid/ready).
It replaces the tied-off direct hookup used in user core wrappers with real flow control:
- busy back-pressure to the core
- posted-write buffer
- read-after-write ordering
- bus timeout with error data
It sits inside user_core_design, between the core instance and the nmi_if master modport.

Parameters:
ADDR_WIDTH, 32, address width on both sides
DATA_WIDTH, 32, data width; strobe width = DATA_WIDTH/8
WBUF_DEPTH, 4, posted-write FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 1024, cycles nmi_valid_o may wait for nmi_ready_i before abort; 0 disables timeout
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
core_addr_i  in  ADDR_WIDTH  core address, held stable while busy
core_wdata_i  in  DATA_WIDTH  core write data
core_wmask_i  in  DATA_WIDTH/8  byte mask; nonzero for one cycle = write request
core_rstrb_i  in  1  one-cycle read request pulse
core_rdata_o  out  DATA_WIDTH  read data, valid in first cycle core_rbusy_o is low after a read
core_rbusy_o  out  1  read in progress
core_wbusy_o  out  1  write not yet accepted
nmi_valid_o  out  1  bus request
nmi_addr_o  out  ADDR_WIDTH  bus address
nmi_wdata_o  out  DATA_WIDTH  bus write data
nmi_wstrb_o  out  DATA_WIDTH/8  byte strobes; 0 = read
nmi_ready_i  in  1  bus completion
nmi_rdata_i  in  DATA_WIDTH  bus read data, sampled when valid&ready
timeout_o  out  1  sticky timeout flag
timeout_clr_i  in  1  clears timeout_o
wbuf_level_o  out  $clog2(WBUF_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0, FIFO emptied, FSM to IDLE, timeout counter 0. Applies mid-transaction; any in-flight request is dropped with no completion.
- Write accept (wmask!=0):
  - FIFO not full: push {addr,wdata,wmask} at that edge; core_wbusy_o stays 0.
  - FIFO full: core_wbusy_o=1 from the next cycle. The pending write is latched in a hold register and pushed when an entry frees. wbusy drops the cycle after the push.
  - The FIFO may pop and push in the same cycle while full; this is accepted with no busy.
- Read accept (rstrb): latch addr; core_rbusy_o=1 from the next cycle.
  - The read is issued only when the FIFO is empty, the hold register is empty and no write is in flight (reads never pass writes).
  - With rbusy high, further strobes are ignored.
- Simultaneous rstrb and wmask!=0: treated as a write; the read is dropped.
- FSM IDLE/WRITE/READ:
  - IDLE -> READ if a read is pending and the write path is drained; else IDLE -> WRITE if the FIFO is non-empty. Requests are issued one cycle after the FSM leaves IDLE.
  - WRITE drives the FIFO head, nmi_wstrb_o=wmask. READ drives the latched addr, nmi_wstrb_o=0.
  - nmi_valid_o and all request fields stay stable until nmi_ready_i. Completion occurs on valid&ready; FSM -> IDLE the same edge.
  - Write completion: pop the head.
  - Read completion: register nmi_rdata_i into core_rdata_o; rbusy drops next cycle.
  - Back-to-back writes: nmi_valid_o deasserts for exactly one cycle between transfers (IDLE cycle).
- Timeout: counter resets on entry to WRITE/READ and increments while valid&!ready.
  - On reaching TIMEOUT_CYCLES: nmi_valid_o drops, timeout_o set. A read returns ERR_DATA; a write entry is popped and discarded. FSM -> IDLE.
  - timeout_clr_i clears timeout_o next cycle; a simultaneous new timeout wins (flag stays set).
- Read latency with empty FIFO and ready on first valid cycle: strobe at C0; nmi_valid_o at C2 (FSM leaves IDLE at C1); completion at C2; rbusy low with data at C3.
- wbuf_level_o reflects FIFO count after each edge, 0..WBUF_DEPTH.

Test Plan:
- Single read, ready tied 1, rdata=32'h1234_5678 -> nmi_valid_o high one cycle with wstrb=0, core_rdata_o=32'h1234_5678 when rbusy falls, total 3 cycles from strobe.
- 6 back-to-back writes (addr 0x100..0x114, wmask 4'hF) with ready held 0, then released -> 4 buffered (wbuf_level_o=4), wbusy=1 on the 5th write, all 6 appear on the bus in order with no loss.
- Write to 0x200 then immediate read of 0x200 with ready delayed 5 cycles -> the read is not issued until the write completes, and the read data returned matches.
- Read with ready never asserted, TIMEOUT_CYCLES=16 -> valid drops after 16 cycles, core_rdata_o=32'hDEAD_BEEF, timeout_o=1; timeout_clr_i pulse -> timeout_o=0.
- rst_i asserted mid-read and mid-full-FIFO -> next cycle all outputs 0, wbuf_level_o=0, no further bus activity.
- Simultaneous rstrb and wmask=4'h3 -> only one write with wstrb=4'h3 on the bus, rbusy stays 0.
